counter_seq_ctrl: RTL and testbench
===================================

# counter_seq_ctrl

Sequencer and two-port arbiter for the bidirectional step counter (reset −50, +5 up / −9 down, range −230..235, value −11 never produced). Two requesters each submit a signed target value. The block grants one at a time and drives the counter's `mode` and `en` until the counter reaches or passes the target. It then reports completion to the winning requester, and aborts on range error or timeout.

## Interface
- `W`, 10, counter/target width (signed)
- `CNT_MIN`, −230, lowest legal counter value
- `CNT_MAX`, 235, highest legal counter value
- `CNT_INV`, −11, value the counter never holds; illegal as a target
- `TMO`, 127, max RUN cycles before abort
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = in reset)
- `req`  in  2  per-requester request; held high with `tgt*` stable until granted
- `tgt0`  in  W  signed target of requester 0
- `tgt1`  in  W  signed target of requester 1
- `gnt`  out  2  one-hot, combinational in IDLE; acceptance occurs at the edge where `gnt[i]` & `req[i]`
- `cnt`  in  W  signed counter value from the datapath
- `en`  out  1  counter step enable; counter updates on edges where `en`=1
- `mode`  out  1  1 = count up, 0 = count down; registered
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle completion pulse
- `done_id`  out  1  requester index, valid with `done`
- `err`  out  1  valid with `done`: 1 = rejected target or timeout

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - Round-robin arbitration over `req`. A `last` pointer gives priority to the requester not served last; after reset, requester 0 has priority.
  - On acceptance:
    - latch `tgt`, `id`;
    - `mode` <= (`tgt` > `cnt`);
    - clear the cycle counter;
    - `last` <= `id`;
    - go to RUN.
- **Target check:**
  - A target is bad if it is < `CNT_MIN`, > `CNT_MAX`, or == `CNT_INV`.
  - A bad target is still accepted (granted), then goes RUN→DONE with `err`=1 and zero steps.
- **RUN:**
  - `reached` = `mode` ? (`cnt` >= `tgt`) : (`cnt` <= `tgt`).
  - `en` = RUN & !`reached` & !bad & (cycle count < `TMO`), combinational.
  - `reached` or bad → DONE with `err`=bad.
  - Cycle count == `TMO` without `reached` → DONE with `err`=1.
  - Overshoot is allowed. The step size means the exact target may be skipped; passing it counts as reached.
- **DONE:** `done`=1 for one cycle with `done_id` and `err`, `gnt`=0; next state IDLE.
- `tgt` equal to `cnt` at acceptance: zero steps, `done` in the second cycle after acceptance, `err`=0.
- Requests arriving during RUN/DONE wait. No grant is issued outside IDLE.
- A `req` dropped before grant is simply not served; there is no error.
- Reset (async, any state):
  - state IDLE, `last` = 1 (so 0 has priority);
  - `en`=0, `mode`=0, `gnt`=0, `busy`=0, `done`=0, `done_id`=0, `err`=0, cycle count 0.
  - Latched target and id are discarded; no `done` is issued for an interrupted job.

## Timing
- Acceptance edge t0.
- RUN from t0. First step when `en`=1 during cycle t0…t0+1, so the counter changes at edge t0+1.
- Completion after n steps: `reached` is seen in the cycle after the n-th step edge. The DONE edge follows; `done` is high for one cycle, then IDLE.
- Minimum request-to-request spacing: acceptance → RUN(1) → DONE(1) → IDLE. The next grant is possible 3 cycles after the previous acceptance.
- `en` never high outside RUN. `mode` is constant throughout a job.
- Comparisons are signed W-bit; no arithmetic wider than W is required.
- The cycle counter is ceil(log2(`TMO`+1)) bits and saturates.

## Structure
- Package `counter_pkg`:
  - `CNT_MIN`, `CNT_MAX`, `CNT_INV`, `CNT_RST` (−50), `W`;
  - typedef `cnt_t` (logic signed [W-1:0]);
  - enum `seq_state_e` {IDLE, RUN, DONE}.
- One sub-module, `rr_arb2`: two-requester round-robin with a `last` input and a one-hot `gnt` output.
- Top-level bench instantiates `counter_seq_ctrl` driving the gated counter, with property checks bound alongside.

## Test plan
- **Reset to up-target:** release reset (`cnt`=−50); `req[0]`=1, `tgt0`=−30 → `gnt`=01, `mode`=1, counter steps −45, −40, −35, −30, `done`=1, `done_id`=0, `err`=0, 4 `en` cycles.
- **Down with overshoot:** from `cnt`=−30, `tgt1`=−50 → `mode`=0, steps −39, −48, −57; stops at −57 ≤ −50, `err`=0.
- **Simultaneous requests:** `req`=11 after requester 0 served last → `gnt`=10 first; requester 0 served next job. After reset `req`=11 → `gnt`=01.
- **Bad target:** `tgt0`=−11, then 240, then −231 → each granted, zero `en` cycles, `done` with `err`=1.
- **Timeout:** stub `cnt` frozen at 0, `tgt0`=200 → `en` high exactly 127 cycles, then `done`, `err`=1.
- **Reset mid-RUN:** assert `rst`=0 during RUN → `en`, `busy`, `gnt`, `done` = 0 immediately. After release, a pending `req[1]` is granted with priority to requester 0 if both are requesting.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and limits for the step counter and its sequencer.
package counter_pkg;

    localparam int W = 10;

    typedef logic signed [W-1:0] cnt_t;

    localparam cnt_t CNT_MIN = cnt_t'(-230);
    localparam cnt_t CNT_MAX = cnt_t'(235);
    localparam cnt_t CNT_INV = cnt_t'(-11);
    localparam cnt_t CNT_RST = cnt_t'(-50);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_e;

    function automatic logic tgt_bad(input cnt_t t);
        return (t < CNT_MIN) || (t > CNT_MAX) || (t == CNT_INV);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the side not served last wins ties.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (req[0] && (last || !req[1])):  gnt = 2'b01;
            (req[1] && (!last || !req[0])): gnt = 2'b10;
            default: ;
        endcase
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer driving the step counter toward a granted requester's target,
// with completion, bad-target rejection and timeout abort.
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int TMO = 127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  cnt_t       tgt0,
    input  cnt_t       tgt1,
    output logic [1:0] gnt,
    input  cnt_t       cnt,
    output logic       en,
    output logic       mode,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic       err
);

    localparam int CW = $clog2(TMO + 1);

    seq_state_e     st;
    cnt_t           tgt;
    cnt_t           sel;
    logic           id;
    logic           last;
    logic [CW-1:0]  cyc;
    logic [1:0]     arb;
    logic           reached;
    logic           bad;
    logic           tmo_hit;

    rr_arb2 u_arb (
        .req  (req),
        .last (last),
        .gnt  (arb)
    );

    // Grant is only visible in IDLE and is forced low while reset is held.
    assign gnt     = (st == IDLE && rst) ? arb : 2'b00;
    assign sel     = arb[1] ? tgt1 : tgt0;
    assign reached = mode ? (cnt >= tgt) : (cnt <= tgt);
    assign bad     = tgt_bad(tgt);
    assign tmo_hit = (cyc == CW'(TMO));
    assign en      = (st == RUN) && !reached && !bad && !tmo_hit;
    assign busy    = (st != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st      <= IDLE;
            tgt     <= '0;
            id      <= 1'b0;
            last    <= 1'b1;
            cyc     <= '0;
            mode    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (|arb) begin
                        tgt  <= sel;
                        id   <= arb[1];
                        last <= arb[1];
                        mode <= (sel > cnt);
                        cyc  <= '0;
                        st   <= RUN;
                    end
                end
                RUN: begin
                    if (reached || bad) begin
                        st      <= DONE;
                        done    <= 1'b1;
                        done_id <= id;
                        err     <= bad;
                    end else if (tmo_hit) begin
                        st      <= DONE;
                        done    <= 1'b1;
                        done_id <= id;
                        err     <= 1'b1;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                DONE: st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench: gated step counter plus sequencer, checked against a job-level model.
module tb_counter_seq_ctrl;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    cnt_t       tgt0 = '0;
    cnt_t       tgt1 = '0;
    cnt_t       cnt;
    logic [1:0] gnt;
    logic       en, mode, busy, done, done_id, err;

    bit   frozen = 1'b0;
    bit   ld_en = 1'b0;
    cnt_t ld_val = '0;
    bit   last_srv = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .tgt0    (tgt0),
        .tgt1    (tgt1),
        .gnt     (gnt),
        .cnt     (cnt),
        .en      (en),
        .mode    (mode),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .err     (err)
    );

    function automatic int cstep(input int c, input bit up);
        int n;
        n = up ? c + 5 : c - 9;
        if (n == -11) n = up ? n + 5 : n - 9;
        if (n < -230) n = -230;
        if (n > 235) n = 235;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) cnt <= cnt_t'(-50);
        else if (ld_en) cnt <= ld_val;
        else if (en && !frozen) cnt <= cnt_t'(cstep(int'(cnt), mode));
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int c, input int t, input bit frz,
                                  output int n, output bit e, output bit m,
                                  output int cf);
        bit badt;
        badt = (t < -230) || (t > 235) || (t == -11);
        m = (t > c);
        n = 0;
        if (!badt)
            while (!(m ? c >= t : c <= t) && n < 127) begin
                if (!frz) c = cstep(c, m);
                n++;
            end
        e = badt || !(m ? c >= t : c <= t);
        cf = c;
    endfunction

    task automatic load(input int v);
        ld_val = cnt_t'(v);
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run_job(input logic [1:0] rv, input int t0, input int t1);
        int win, t, n_exp, n_en, lat, cf;
        bit e_err, e_mode, ok, seen;
        win = (rv == 2'b11) ? int'(!last_srv) : int'(rv[1]);
        t = win ? t1 : t0;
        model(int'(cnt), t, frozen, n_exp, e_err, e_mode, cf);
        req = rv;
        tgt0 = cnt_t'(t0);
        tgt1 = cnt_t'(t1);
        #1;
        check("gnt", gnt, win ? 2 : 1);
        @(posedge clk);
        #1;
        req = 2'b00;
        last_srv = win[0];
        check("mode", mode, e_mode);
        n_en = 0;
        lat = 0;
        seen = 0;
        ok = 1;
        while (!seen && lat < 300) begin
            @(negedge clk);
            lat++;
            if (en) n_en++;
            if (mode !== e_mode || gnt !== 2'b00 || busy !== 1'b1) ok = 0;
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        check("latency", lat, n_exp + 2);
        check("en_cycles", n_en, n_exp);
        check("done_id", done_id, win);
        check("err", err, e_err);
        check("job_stable", ok, 1);
        check("cnt_end", int'(cnt), cf);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int pick, t0, t1;
        logic [1:0] rv;
        int bads[3];
        bads[0] = -11;
        bads[1] = 240;
        bads[2] = -231;

        req = 2'b11;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_en", en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mode", mode, 0);
        check("rst_cnt", int'(cnt), -50);
        rst = 1'b1;
        req = 2'b00;
        last_srv = 1'b1;

        run_job(2'b11, -30, 0);
        run_job(2'b10, 0, -50);
        run_job(2'b11, 20, 40);
        run_job(2'b11, -100, 100);
        for (int i = 0; i < 3; i++) run_job(2'b01, bads[i], 0);
        run_job(2'b10, 0, int'(cnt));

        load(0);
        frozen = 1'b1;
        run_job(2'b01, 200, 0);
        frozen = 1'b0;

        for (int i = 0; i < 24; i++) begin
            rv = 2'($urandom_range(1, 3));
            pick = int'($urandom_range(0, 5));
            t0 = (pick == 0) ? bads[$urandom_range(0, 2)]
                             : int'($urandom_range(0, 465)) - 230;
            t1 = int'($urandom_range(0, 465)) - 230;
            run_job(rv, t0, t1);
        end

        load(-200);
        req = 2'b01;
        tgt0 = cnt_t'(200);
        @(posedge clk);
        #1;
        req = 2'b00;
        repeat (3) @(negedge clk);
        check("mid_en", en, 1);
        #2;
        rst = 1'b0;
        req = 2'b11;
        #1;
        check("mid_rst_en", en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        last_srv = 1'b1;
        #1;
        check("post_rst_gnt", gnt, 1);
        run_job(2'b11, -20, 30);
        run_job(2'b10, 0, -80);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
